// File: rtl/fetch_unit_vl.sv
// rtl/fetch_unit_vl.sv - variable-length instruction fetch stage with loadable instruction memory
module fetch_unit_vl #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 32,
    parameter int                MEM_AW   = 10,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  stall,
    input  logic                  br_en,
    input  logic [ADDR_W-1:0]     br_target,
    output logic [2*DATA_W-1:0]   instr_out,
    output logic [ADDR_W-1:0]     instr_pc,
    output logic                  instr_valid,
    output logic                  instr_long
);

    localparam int DEPTH = 2 ** MEM_AW;

    // F1: expecting the first word of an instruction; F2: holding a long opcode word
    typedef enum logic {
        F1 = 1'b0,
        F2 = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic [DATA_W-1:0]     mem [DEPTH];

    logic [ADDR_W-1:0]     pc;
    logic [ADDR_W-1:0]     pc_nxt;
    logic [DATA_W-1:0]     hw;
    logic [DATA_W-1:0]     hw_nxt;
    logic [ADDR_W-1:0]     hpc;
    logic [ADDR_W-1:0]     hpc_nxt;

    logic [2*DATA_W-1:0]   instr_out_nxt;
    logic [ADDR_W-1:0]     instr_pc_nxt;
    logic                  instr_valid_nxt;
    logic                  instr_long_nxt;

    logic [DATA_W-1:0]     w;
    logic                  w_long;
    logic                  advance;
    logic [ADDR_W-1:0]     pc_inc;

    // Only the low MEM_AW address bits index memory; the rest alias by design
    logic                  unused_wr_addr_hi;
    assign unused_wr_addr_hi = &{1'b0, wr_addr[ADDR_W-1:MEM_AW]};

    // Combinational read at the current PC; upper PC bits alias onto the array
    assign w       = mem[pc[MEM_AW-1:0]];
    assign w_long  = w[DATA_W-1];
    assign advance = !br_en && !wr_en && !stall;
    assign pc_inc  = pc + {{(ADDR_W-1){1'b0}}, 1'b1};

    // Loader port: memory is not reset so loaded code survives a reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr[MEM_AW-1:0]] <= wr_data;
        end
    end

    // State, PC, hold registers and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= F1;
            pc          <= RESET_PC;
            hw          <= '0;
            hpc         <= '0;
            instr_out   <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            instr_long  <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            hw          <= hw_nxt;
            hpc         <= hpc_nxt;
            instr_out   <= instr_out_nxt;
            instr_pc    <= instr_pc_nxt;
            instr_valid <= instr_valid_nxt;
            instr_long  <= instr_long_nxt;
        end
    end

    // Next-state: redirect always returns to F1; freezes hold; a long opcode enters F2
    always_comb begin
        state_nxt = state;
        if (br_en) begin
            state_nxt = F1;
        end else if (advance) begin
            case (state)
                F1:      state_nxt = w_long ? F2 : F1;
                F2:      state_nxt = F1;
                default: state_nxt = F1;
            endcase
        end
    end

    // Datapath and output next values; everything holds unless redirected or fetching
    always_comb begin
        pc_nxt          = pc;
        hw_nxt          = hw;
        hpc_nxt         = hpc;
        instr_out_nxt   = instr_out;
        instr_pc_nxt    = instr_pc;
        instr_valid_nxt = instr_valid;
        instr_long_nxt  = instr_long;
        if (br_en) begin
            // Partial long fetch is dropped simply by forcing F1; hw/hpc go stale
            pc_nxt          = br_target;
            instr_valid_nxt = 1'b0;
            instr_long_nxt  = 1'b0;
        end else if (advance) begin
            pc_nxt = pc_inc;
            case (state)
                F1: begin
                    if (w_long) begin
                        hw_nxt          = w;
                        hpc_nxt         = pc;
                        instr_valid_nxt = 1'b0;
                    end else begin
                        instr_out_nxt   = {w, {DATA_W{1'b0}}};
                        instr_pc_nxt    = pc;
                        instr_valid_nxt = 1'b1;
                        instr_long_nxt  = 1'b0;
                    end
                end
                F2: begin
                    // Second word is pure immediate data; its MSB is not a flag
                    instr_out_nxt   = {hw, w};
                    instr_pc_nxt    = hpc;
                    instr_valid_nxt = 1'b1;
                    instr_long_nxt  = 1'b1;
                end
                default: begin
                    instr_valid_nxt = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit_vl.sv
// tb/tb_fetch_unit_vl.sv - directed bench with behavioural fetch model for fetch_unit_vl
module tb_fetch_unit_vl;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [15:0] wr_data;
    logic        stall;
    logic        br_en;
    logic [31:0] br_target;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_long;

    int vectors = 0;
    int miscompares = 0;

    fetch_unit_vl dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .stall       (stall),
        .br_en       (br_en),
        .br_target   (br_target),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_long  (instr_long)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a word stream with an optional pending opcode word
    logic [15:0] m_mem [1024];
    logic [31:0] m_pc  = 32'h0;
    logic [31:0] m_out = 32'h0;
    logic [31:0] m_ipc = 32'h0;
    logic        m_valid = 1'b0;
    logic        m_long  = 1'b0;
    logic [15:0] pend_w [$];
    logic [31:0] pend_pc [$];

    initial begin
        logic [15:0] w;
        for (int i = 0; i < 1024; i++) m_mem[i] = 16'h0;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_pc = 32'h0; m_out = 32'h0; m_ipc = 32'h0;
                m_valid = 1'b0; m_long = 1'b0;
                pend_w.delete(); pend_pc.delete();
                if (clk && wr_en) m_mem[wr_addr[9:0]] = wr_data;
            end else begin
                w = m_mem[m_pc[9:0]];
                if (br_en) begin
                    m_pc = br_target; m_valid = 1'b0; m_long = 1'b0;
                    pend_w.delete(); pend_pc.delete();
                end else if (!wr_en && !stall) begin
                    if (pend_w.size() != 0) begin
                        m_out = {pend_w.pop_front(), w};
                        m_ipc = pend_pc.pop_front();
                        m_valid = 1'b1; m_long = 1'b1;
                    end else if (w[15]) begin
                        pend_w.push_back(w); pend_pc.push_back(m_pc);
                        m_valid = 1'b0;
                    end else begin
                        m_out = {w, 16'h0}; m_ipc = m_pc;
                        m_valid = 1'b1; m_long = 1'b0;
                    end
                    m_pc = m_pc + 32'h1;
                end
                if (wr_en) m_mem[wr_addr[9:0]] = wr_data;
            end
        end
    end

    // Compare DUT against model on every falling edge
    initial begin
        forever begin
            @(negedge clk);
            chk("model_out", instr_out, m_out);
            chk("model_pc", instr_pc, m_ipc);
            chk("model_valid", {31'h0, instr_valid}, {31'h0, m_valid});
            chk("model_long", {31'h0, instr_long}, {31'h0, m_long});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic br(input logic [31:0] t);
        br_en = 1'b1; br_target = t;
        cyc();
        chk("br_valid", {31'h0, instr_valid}, 32'h0);
        chk("br_long", {31'h0, instr_long}, 32'h0);
        br_en = 1'b0;
    endtask

    task automatic expect_instr(input logic [31:0] o, input logic [31:0] p, input logic l);
        cyc();
        chk("lit_out", instr_out, o);
        chk("lit_pc", instr_pc, p);
        chk("lit_valid", {31'h0, instr_valid}, 32'h1);
        chk("lit_long", {31'h0, instr_long}, {31'h0, l});
    endtask

    logic [31:0] la [12] = '{32'h20, 32'h21, 32'h22, 32'h23, 32'h24,
                             32'h30, 32'h31, 32'h32, 32'h3FF, 32'h0, 32'h40, 32'h41};
    logic [15:0] ld [12] = '{16'h0070, 16'h0071, 16'h0072, 16'h0073, 16'h0074,
                             16'h8123, 16'hBEEF, 16'h0005, 16'h8001, 16'h1234, 16'h0000, 16'h0000};

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_addr = 32'h0; wr_data = 16'h0;
        stall = 1'b0; br_en = 1'b0; br_target = 32'h0;

        // Reset held: all outputs zero
        repeat (3) begin
            cyc();
            chk("rst_out", instr_out, 32'h0);
            chk("rst_pc", instr_pc, 32'h0);
            chk("rst_valid", {31'h0, instr_valid}, 32'h0);
            chk("rst_long", {31'h0, instr_long}, 32'h0);
        end

        // Load program; fetch frozen
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            wr_en = 1'b1; wr_addr = la[i]; wr_data = ld[i];
            cyc();
            chk("load_valid", {31'h0, instr_valid}, 32'h0);
        end
        wr_en = 1'b0;

        // Short instructions and stall
        br(32'h20);
        expect_instr(32'h00700000, 32'h20, 1'b0);
        expect_instr(32'h00710000, 32'h21, 1'b0);
        stall = 1'b1;
        repeat (3) begin
            cyc();
            chk("stall_out", instr_out, 32'h00710000);
            chk("stall_pc", instr_pc, 32'h21);
            chk("stall_valid", {31'h0, instr_valid}, 32'h1);
        end
        stall = 1'b0;
        expect_instr(32'h00720000, 32'h22, 1'b0);
        expect_instr(32'h00730000, 32'h23, 1'b0);
        expect_instr(32'h00740000, 32'h24, 1'b0);

        // Long instruction
        br(32'h30);
        cyc();
        chk("long_gap", {31'h0, instr_valid}, 32'h0);
        expect_instr(32'h8123BEEF, 32'h30, 1'b1);
        expect_instr(32'h00050000, 32'h32, 1'b0);

        // Redirect while in F2 and stalled
        br(32'h30);
        cyc();
        chk("f2_valid", {31'h0, instr_valid}, 32'h0);
        stall = 1'b1; br_en = 1'b1; br_target = 32'h20;
        cyc();
        chk("f2br_valid", {31'h0, instr_valid}, 32'h0);
        chk("f2br_hold", instr_out, 32'h00050000);
        br_en = 1'b0; stall = 1'b0;
        expect_instr(32'h00700000, 32'h20, 1'b0);

        // Write to second word during F2 freeze is seen on resume
        br(32'h30);
        cyc();
        wr_en = 1'b1; wr_addr = 32'h31; wr_data = 16'hCAFE;
        cyc();
        chk("frz_valid", {31'h0, instr_valid}, 32'h0);
        wr_en = 1'b0;
        expect_instr(32'h8123CAFE, 32'h30, 1'b1);

        // PC wrap straddling a long instruction
        br(32'hFFFFFFFF);
        cyc();
        chk("wrap_gap", {31'h0, instr_valid}, 32'h0);
        expect_instr(32'h80011234, 32'hFFFFFFFF, 1'b1);

        // Asynchronous reset mid-F2
        br(32'hFFFFFFFF);
        cyc();
        rst = 1'b0;
        #1;
        chk("arst_out", instr_out, 32'h0);
        chk("arst_pc", instr_pc, 32'h0);
        chk("arst_valid", {31'h0, instr_valid}, 32'h0);
        chk("arst_long", {31'h0, instr_long}, 32'h0);
        #2;
        rst = 1'b1;
        expect_instr(32'h12340000, 32'h0, 1'b0);
        stall = 1'b1;
        cyc();
        cyc();
        chk("end_out", instr_out, 32'h12340000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit_vl.md
Name: fetch_unit_vl

Overview:
Parametrised instruction fetch stage with an integrated loadable instruction memory. It supports variable-length instructions: a short instruction is one word, and a long instruction is two words (opcode word plus immediate word). It also supports downstream stall and branch redirect. It sits between the PC/branch logic and the decode stage and presents one registered, double-word-wide instruction per accepted fetch.

Parameters:
DATA_W, 16, width of one memory word (instruction word).
ADDR_W, 32, width of PC, write address and branch target.
MEM_AW, 10, memory index width; depth = 2**MEM_AW words.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-low reset (0 = reset).
wr_en  input  1  loader write enable; while 1, fetch is frozen.
wr_addr  input  ADDR_W  loader word address; low MEM_AW bits index memory.
wr_data  input  DATA_W  loader word.
stall  input  1  decode not ready; freezes fetch and holds outputs.
br_en  input  1  redirect request.
br_target  input  ADDR_W  redirect PC.
instr_out  output  2*DATA_W  {first word, second word}; second word is 0 for short instructions.
instr_pc  output  ADDR_W  PC of the first word of instr_out.
instr_valid  output  1  instr_out/instr_pc hold a fetched instruction.
instr_long  output  1  instr_out is a two-word instruction.

Behaviour:
- Memory: DEPTH words of DATA_W, not reset; contents survive rst.
  - Write is synchronous when wr_en=1: mem[wr_addr[MEM_AW-1:0]] <= wr_data.
  - Read is combinational at index pc[MEM_AW-1:0]; upper PC bits alias.
- Internal state: pc (ADDR_W), fsm {F1, F2}, hold word hw (DATA_W), hold pc hpc (ADDR_W).
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, fsm=F1, hw=0, hpc=0.
  - instr_out=0, instr_pc=0, instr_valid=0, instr_long=0.
  - A reset mid long-fetch discards the partial word.
- Let w = mem[pc]. Long flag = w[DATA_W-1]. All outputs are registered.
- Per-edge priority: br_en > wr_en > stall > normal fetch.
- br_en=1:
  - pc<=br_target, fsm<=F1, instr_valid<=0, instr_long<=0. instr_out/instr_pc hold.
  - Any F2 partial is discarded.
  - Overrides stall and wr_en freeze; a concurrent memory write still occurs.
- wr_en=1 (no br_en): memory written; pc, fsm, hw, hpc and all outputs hold.
- stall=1 (no br_en, no wr_en): pc, fsm, hw, hpc and all outputs hold.
- Normal fetch in F1, short (w[MSB]=0):
  - instr_out<={w, 0}, instr_pc<=pc, instr_valid<=1, instr_long<=0, pc<=pc+1, fsm stays F1.
- Normal fetch in F1, long (w[MSB]=1):
  - hw<=w, hpc<=pc, pc<=pc+1, instr_valid<=0, fsm<=F2.
- Normal fetch in F2:
  - instr_out<={hw, w}, instr_pc<=hpc, instr_valid<=1, instr_long<=1, pc<=pc+1, fsm<=F1.
  - The second word's MSB is data and is never decoded as a flag.
- Latency: first valid output 1 edge after redirect/reset release for a short instruction, 2 edges for a long one.
- Throughput: 1 short per cycle, 1 long per 2 cycles.
- PC arithmetic is modulo 2**ADDR_W: 0xFFFFFFFF+1 = 0x00000000. A long instruction may straddle this wrap.
- Freeze in F2 (stall or wr_en) retains hw/hpc. On resume, the second word is read from current memory, including any word written during the freeze.

Test Plan:
1. Reset: hold rst=0, toggle clk 3 cycles, with stall=0, wr_en=0, br_en=0 -> instr_out=0, instr_pc=0, instr_valid=0, instr_long=0 throughout.
2. Load then fetch shorts: write 0x0070..0x0074 to addresses 0x20..0x24 (wr_en=1, one per cycle); instr_valid must stay 0 during the load. Then pulse br_en with target 0x20 -> next edges give instr_out=0x00700000/pc 0x20, 0x00710000/pc 0x21, ... 0x00740000/pc 0x24, instr_valid=1 each cycle.
3. Long instruction: mem[0x30]=0x8123, mem[0x31]=0xBEEF, mem[0x32]=0x0005; redirect to 0x30 -> one edge with instr_valid=0, then 0x8123BEEF/pc 0x30/long=1, then 0x00050000/pc 0x32/long=0.
4. Stall: assert stall 3 cycles while instr_out=0x00710000 -> outputs and pc unchanged. Deassert -> 0x00720000 follows on the next edge.
5. Redirect in F2 with stall=1: redirect to 0x20 while hw=0x8123 -> instr_valid=0 next edge, then 0x00700000/pc 0x20; 0x8123 is never emitted.
6. Wrap and async reset: redirect to 0xFFFFFFFF with mem[0x3FF]=0x8001 and mem[0x000]=0x1234 -> instr_out=0x80011234, instr_pc=0xFFFFFFFF. Then drop rst mid-F2 between clock edges -> all outputs 0 immediately, and the first post-reset fetch comes from RESET_PC.
